regfile_scoreboard: RTL

- Parametrised next-generation general-purpose register file for the pipelined RISC-8 core.
- Two combinational read ports and two synchronous write ports, plus an integrated per-register busy scoreboard.
- The decode stage uses the busy flags for hazard stalls. Writeback clears them; issue sets them; a flush clears all of them.

---
 rtl/regfile_scoreboard.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, two synchronous write
// ports and a per-register busy scoreboard for decode-stage hazard stalls.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic              rd1_busy_o,
    output logic              rd2_busy_o,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_rd_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_cnt_o
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam bit          ZeroEn = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  set_vec, clr_vec;

    // Next register contents: port 1 is applied last so it wins a same-address conflict.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (we0_i && (wa0_i == ADDR_W'(r))) regs_d[r] = wd0_i;
            if (we1_i && (wa1_i == ADDR_W'(r))) regs_d[r] = wd1_i;
            if (ZeroEn && (r == 0))             regs_d[r] = '0;
        end
    end

    // Next busy vector: flush beats set, set beats writeback clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        busy_d  = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            set_vec[r] = iss_valid_i && (iss_rd_i == ADDR_W'(r));
            clr_vec[r] = (we0_i && (wa0_i == ADDR_W'(r))) || (we1_i && (wa1_i == ADDR_W'(r)));
            busy_d[r]  = flush_i ? 1'b0 : (set_vec[r] | (busy_q[r] & ~clr_vec[r]));
            if (ZeroEn && (r == 0)) busy_d[r] = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Returns {busy, data} for one read address.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              zero_addr;
        zero_addr = ZeroEn && (ra == '0);
        data      = regs_q[ra];
        busy      = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (!zero_addr) begin
            if (we1_i && (wa1_i == ra)) begin
                data = wd1_i;
                if (!(iss_valid_i && (iss_rd_i == ra))) busy = 1'b0;
            end else if (we0_i && (wa0_i == ra)) begin
                data = wd0_i;
                if (!(iss_valid_i && (iss_rd_i == ra))) busy = 1'b0;
            end
        end
`endif
        if (zero_addr) data = '0;
        return {busy, data};
    endfunction

    // Read port 1.
    always_comb begin
        {rd1_busy_o, rd1_o} = read_port(ra1_i);
    end

    // Read port 2.
    always_comb begin
        {rd2_busy_o, rd2_o} = read_port(ra2_i);
    end

    // Population count of the registered busy vector.
    always_comb begin
        busy_cnt_o = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            busy_cnt_o = busy_cnt_o + (ADDR_W + 1)'(busy_q[r]);
        end
    end

endmodule
